arb_mux_n: RTL and testbench
============================

ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel, >=1.
REQ-002 SHALL have parameter N, default 4: input channel count, 2..16.
REQ-003 SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SHALL define SW = clog2(N) as the channel-index width.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, N: per-channel data valid.
REQ-009 SHALL have port in_ready, output, N: per-channel accept, combinational.
REQ-010 SHALL have port sel, input, SW: channel select, used only when MODE=0.
REQ-011 SHALL have port out_data, output, WIDTH: registered selected word.
REQ-012 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts when high with out_valid.
REQ-014 SHALL have port out_chan, output, SW: source channel index of out_data.

Function
REQ-015 SHALL contain one output register stage (out_data, out_valid, out_chan) and, for MODE=1, one SW-bit round-robin pointer ptr.
REQ-016 SHALL define space = !out_valid || out_ready; the stage accepts a new word only when space=1.
REQ-017 MODE=0: grant = sel when sel < N; sel >= N grants no channel and all in_ready SHALL be 0.
REQ-018 MODE=1: grant = first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N; no valid input means no grant.
REQ-019 SHALL drive in_ready[i] = space && (i == grant) for a granted channel, and 0 for all other channels.
REQ-020 MODE=0 in_ready SHALL NOT depend on in_valid; MODE=1 in_ready MAY depend on in_valid of other channels only.
REQ-021 A load occurs when in_valid[grant] && in_ready[grant]; on load, next cycle out_data = granted word, out_chan = grant, out_valid = 1.
REQ-022 Latency SHALL be exactly 1 cycle, input handshake to out_valid; throughput 1 word/cycle with out_ready held high.
REQ-023 When out_valid && out_ready and no load, out_valid SHALL clear next cycle; out_data and out_chan SHALL hold their values.
REQ-024 When out_valid && !out_ready, out_data, out_chan and out_valid SHALL hold stable; all in_ready SHALL be 0.
REQ-025 Simultaneous output consume and load SHALL replace the word with no bubble, and out_valid SHALL stay 1.
REQ-026 MODE=1: on load, ptr SHALL update to grant+1, with N-1 wrapping to 0; ptr SHALL hold when no load occurs.
REQ-027 MODE=1: a channel held valid SHALL be granted within N loads (starvation-free).
REQ-028 MODE=0: ptr SHALL be unused and held at 0.
REQ-029 sel SHALL be sampled combinationally each cycle; a change while the output is stalled SHALL NOT alter the held word.

Reset
REQ-030 reset_n=0 SHALL asynchronously force out_valid=0, out_data=0, out_chan=0 and ptr=0.
REQ-031 A held, unconsumed word SHALL be discarded on reset; in_ready SHALL be 0 while reset_n=0.
REQ-032 Release SHALL be synchronous to clk; the first load can occur on the first rising edge after reset_n=1.

Verification
REQ-033 MODE=0, N=4, sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
REQ-034 MODE=0, sel=5 with N=4 -> in_ready=0000 and out_valid stays 0.
REQ-035 MODE=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,... with one word per cycle.
REQ-036 out_ready=0 for 3 cycles while holding word A, inputs valid -> out_data=A stable and in_ready=0; out_ready=1 -> next word loads in the same cycle A is consumed.
REQ-037 MODE=1, only ch3 valid, ptr=1 -> grant=3; after load ptr=0; then ch0 and ch3 both valid -> ch0 granted.
REQ-038 reset_n pulsed low mid-cycle while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge; after release, ptr=0 and the first grant follows REQ-018.

Source files
------------

// File: rtl/arb_mux_n.sv
// N-to-1 channel multiplexer with a single registered output stage.
// Grant comes from an explicit select (MODE=0) or a round-robin pointer (MODE=1).
module arb_mux_n #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned MODE  = 0,
   localparam int unsigned SW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SW-1:0]      sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SW-1:0]      out_chan
);

   logic [SW-1:0]    ptr;
   logic [SW-1:0]    grant;
   logic             grant_vld;
   logic             space;
   logic             load;
   logic [WIDTH-1:0] grant_word;
   logic [2*N-1:0]   valid_dbl;
   logic [N-1:0]     valid_rot;
   logic [SW:0]      grant_sum;

   assign space = !out_valid || out_ready;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      grant_sum = '0;
      // Rotate so bit 0 is the channel at ptr; the lowest set bit wins.
      valid_dbl = {in_valid, in_valid} >> ptr;
      valid_rot = valid_dbl[N-1:0];
      if (MODE == 0) begin
         if (32'(sel) < N) begin
            grant     = sel;
            grant_vld = 1'b1;
         end
      end else begin
         for (int j = N - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
               grant_sum = {1'b0, ptr} + (SW + 1)'(j);
               grant_vld = 1'b1;
            end
         end
         if (32'(grant_sum) >= N) begin
            grant = SW'(grant_sum - (SW + 1)'(N));
         end else begin
            grant = SW'(grant_sum);
         end
      end
   end

   always_comb begin
      grant_word = '0;
      in_ready   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SW'(i)) begin
            grant_word  = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = reset_n && space && grant_vld;
         end
      end
   end

   assign load = |(in_valid & in_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_chan  <= '0;
         ptr       <= '0;
      end else begin
         if (load) begin
            out_data  <= grant_word;
            out_chan  <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (MODE == 1 && load) begin
            ptr <= (32'(grant) == N - 1) ? '0 : grant + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: select-mode and round-robin instances checked every cycle against a
// behavioural model, plus directed literal checks and a non-power-of-two select instance.
module tb_arb_mux_n;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [127:0] in_data = '0;
   logic [3:0]   in_valid = '0;
   logic [1:0]   sel = '0;
   logic         out_ready = 1'b0;

   logic [3:0]   rdy0, rdy1;
   logic [31:0]  od0, od1;
   logic         ov0, ov1;
   logic [1:0]   oc0, oc1;

   logic [39:0]  d2_data = '0;
   logic [4:0]   d2_valid = '0;
   logic [2:0]   d2_sel = '0;
   logic         d2_oready = 1'b0;
   logic [4:0]   rdy2;
   logic [7:0]   od2;
   logic         ov2;
   logic [2:0]   oc2;

   int total = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   arb_mux_n #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_chan(oc0));

   arb_mux_n #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_chan(oc1));

   arb_mux_n #(.WIDTH(8), .N(5), .MODE(0)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_data(d2_data), .in_valid(d2_valid), .in_ready(rdy2),
      .sel(d2_sel), .out_data(od2), .out_valid(ov2), .out_ready(d2_oready), .out_chan(oc2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Model state for dut0 (index 0) and dut1 (index 1).
   bit          m_valid[2];
   logic [31:0] m_data[2];
   int          m_chan[2];
   int          m_ptr[2];

   function automatic int grant_of(input int mode, input int ptr, input logic [1:0] s,
                                   input logic [3:0] v);
      if (mode == 0) return int'(s);
      for (int k = 0; k < 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_chan[d]  = 0;
            m_ptr[d]   = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            int g;
            g = grant_of(d, m_ptr[d], sel, in_valid);
            if (g >= 0 && in_valid[g] && (!m_valid[d] || out_ready)) begin
               m_valid[d] = 1'b1;
               m_data[d]  = in_data[g*32 +: 32];
               m_chan[d]  = g;
               if (d == 1) m_ptr[d] = (g + 1) % 4;
            end else if (out_ready) begin
               m_valid[d] = 1'b0;
            end
         end
      end
   end

   task automatic cmp(input int d, input logic ov, input logic [31:0] od, input logic [1:0] oc,
                      input logic [3:0] rdy);
      int g;
      logic [3:0] er;
      g  = grant_of(d, m_ptr[d], sel, in_valid);
      er = '0;
      if (reset_n && g >= 0 && (!m_valid[d] || out_ready)) er[g] = 1'b1;
      check($sformatf("dut%0d out_valid", d), 32'(ov), 32'(m_valid[d]));
      check($sformatf("dut%0d out_data", d), od, m_data[d]);
      check($sformatf("dut%0d out_chan", d), 32'(oc), 32'(m_chan[d]));
      check($sformatf("dut%0d in_ready", d), 32'(rdy), 32'(er));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, ov0, od0, oc0, rdy0);
         cmp(1, ov1, od1, oc1, rdy1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset_n = 1'b0;
      chk_en    = 1'b1;
      d2_sel    = 3'd5;
      d2_valid  = 5'b11111;
      d2_oready = 1'b1;
      d2_data   = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      check("reset in_ready dut0", 32'(rdy0), 32'h0);
      check("reset in_ready dut1", 32'(rdy1), 32'h0);
      repeat (3) step();
      check("reset out_valid", 32'(ov0), 32'h0);
      check("reset out_data", od0, 32'h0);
      check("reset out_chan", 32'(oc1), 32'h0);

      // Release, then load the first word on the very next edge.
      reset_n  = 1'b1;
      in_valid = 4'b0100;
      sel      = 2'd2;
      in_data  = {32'hA3A3A3A3, 32'hDEADBEEF, 32'hA1A1A1A1, 32'hA0A0A0A0};
      #1;
      check("first in_ready dut0", 32'(rdy0), 32'h4);
      check("first in_ready dut1", 32'(rdy1), 32'h4);
      check("sel>=N in_ready", 32'(rdy2), 32'h0);
      step();
      in_valid = 4'b0000;
      check("first out_valid", 32'(ov0), 32'h1);
      check("first out_data", od0, 32'hDEADBEEF);
      check("first out_chan", 32'(oc0), 32'h2);
      check("first rr chan", 32'(oc1), 32'h2);
      check("sel>=N out_valid", 32'(ov2), 32'h0);
      d2_sel = 3'd7;
      step();
      check("drain out_valid", 32'(ov0), 32'h0);
      check("drain data hold", od0, 32'hDEADBEEF);
      check("drain chan hold", 32'(oc0), 32'h2);
      check("sel=7 in_ready", 32'(rdy2), 32'h0);
      check("sel=7 out_valid", 32'(ov2), 32'h0);

      // Asynchronous reset pulse while words are held.
      in_valid = 4'b0001;
      sel      = 2'd0;
      step();
      in_valid = 4'b0000;
      check("pre-pulse out_valid", 32'(ov1), 32'h1);
      #1 reset_n = 1'b0;
      #1;
      check("async reset dut0", 32'(ov0), 32'h0);
      check("async reset dut1", 32'(ov1), 32'h0);
      #1 reset_n = 1'b1;

      // Round-robin with every channel valid: 0,1,2,3,0 back to back.
      in_valid = 4'b1111;
      sel      = 2'd1;
      in_data  = {32'd103, 32'd102, 32'd101, 32'd100};
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("rr chan %0d", k), 32'(oc1), 32'(k % 4));
         check($sformatf("rr data %0d", k), od1, 32'(100 + k % 4));
         check($sformatf("rr valid %0d", k), 32'(ov1), 32'h1);
      end
      check("sel stream chan", 32'(oc0), 32'h1);

      // Stall three cycles; a sel change must not disturb the held word.
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) sel = 2'd3;
         #1;
         check("stall in_ready dut0", 32'(rdy0), 32'h0);
         check("stall in_ready dut1", 32'(rdy1), 32'h0);
         step();
         check("stall data dut0", od0, 32'd101);
         check("stall chan dut0", 32'(oc0), 32'h1);
         check("stall data dut1", od1, 32'd100);
      end
      out_ready = 1'b1;
      step();
      check("replace data dut0", od0, 32'd103);
      check("replace valid dut0", 32'(ov0), 32'h1);
      check("replace chan dut1", 32'(oc1), 32'h1);

      // Pointer walk: ptr=2 -> ch0 (ptr 1), only ch3 -> ch3 (ptr 0), ch0+ch3 -> ch0.
      in_valid = 4'b0001;
      step();
      check("walk ch0", 32'(oc1), 32'h0);
      in_valid = 4'b1000;
      step();
      check("walk ch3", 32'(oc1), 32'h3);
      in_valid = 4'b1001;
      step();
      check("walk wrap ch0", 32'(oc1), 32'h0);

      d2_sel = 3'd4;
      step();
      check("n5 chan", 32'(oc2), 32'h4);
      check("n5 data", 32'(od2), 32'h44);
      check("n5 valid", 32'(ov2), 32'h1);

      // Mixed traffic against the model.
      for (int r = 0; r < 80; r++) begin
         in_valid  = 4'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
